// File: rtl/fetch_pkg.sv
// Shared opcode constants and state encoding for the fetch stage.
// The hazard unit imports the same opcode constants.
package fetch_pkg;

    localparam logic [3:0]  OP_BR0   = 4'b0100;
    localparam logic [3:0]  OP_BR1   = 4'b0101;
    localparam logic [3:0]  OP_HALT  = 4'b1111;
    localparam logic [31:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_BR = 2'd1,
        HALT    = 2'd2
    } fetch_state_t;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BR0) || (op == OP_BR1);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-ROM bus: the fetch stage presents the next PC, the ROM returns
// that word one clock later.
interface fetch_stage_if #(
    parameter int IW = 32,
    parameter int AW = 10
);
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register. Branches freeze fetch until
// writeback resolves them; HALT freezes fetch until reset.
//
//   state   | meaning
//   RUN     | sequential fetch, decode register loads fetched words
//   WAIT_BR | branch in flight, pc_F frozen at branch+1, decode gets bubbles
//   HALT    | halt opcode decoded, fetch frozen until rst
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int IW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_F,
    input  logic          stall_D,
    input  logic          Flush_D,
    input  logic          PC_W,
    input  logic          BranchTaken_W,
    input  logic [AW-1:0] PCTarget_W,
    fetch_stage_if.master imem,
    output logic [IW-1:0] instr_D,
    output logic [AW-1:0] pc_D,
    output logic          valid_D,
    output logic [3:0]    op_D,
    output logic          branch_pending,
    output logic          halted
);

    fetch_state_t  state_q, state_nxt;
    logic [AW-1:0] pc_F, pc_nxt;
    logic          load_D;
    logic [3:0]    fetch_op;

    assign fetch_op = imem.imem_rdata[IW-1:IW-4];
    assign load_D   = (state_q == RUN) && !Flush_D && !stall_F;

    // Redirect outranks stall_F so a resolved branch is never lost.
    always_comb begin
        pc_nxt = pc_F;
        if (rst) begin
            pc_nxt = '0;
        end else if (state_q == WAIT_BR && PC_W) begin
            pc_nxt = BranchTaken_W ? PCTarget_W : pc_F;
        end else if (state_q != RUN || stall_F) begin
            pc_nxt = pc_F;
        end else begin
            pc_nxt = pc_F + 1'b1;
        end
    end

    assign imem.imem_addr = pc_nxt;

    // Only opcodes that really land in decode can change state.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            RUN: begin
                if (load_D && !stall_D) begin
                    if (is_branch(fetch_op)) begin
                        state_nxt = WAIT_BR;
                    end else if (fetch_op == OP_HALT) begin
                        state_nxt = HALT;
                    end
                end
            end
            WAIT_BR: begin
                if (PC_W) begin
                    state_nxt = RUN;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        pc_F <= pc_nxt;
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_D <= IW'(NOP_WORD);
            pc_D    <= '0;
            valid_D <= 1'b0;
        end else if (!stall_D) begin
            if (load_D) begin
                instr_D <= imem.imem_rdata;
                pc_D    <= pc_F;
                valid_D <= 1'b1;
            end else begin
                instr_D <= IW'(NOP_WORD);
                pc_D    <= '0;
                valid_D <= 1'b0;
            end
        end
    end

    assign op_D           = instr_D[IW-1:IW-4];
    assign branch_pending = (state_q == WAIT_BR);
    assign halted         = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a registered ROM model feeds the stage and a
// scoreboard of expected (pc, word) pairs is drained as words reach decode.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam int IW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_F, stall_D, Flush_D;
    logic          PC_W, BranchTaken_W;
    logic [AW-1:0] PCTarget_W;
    logic [IW-1:0] instr_D;
    logic [AW-1:0] pc_D;
    logic          valid_D;
    logic [3:0]    op_D;
    logic          branch_pending, halted;

    fetch_stage_if #(.IW(IW), .AW(AW)) imem_bus ();

    fetch_stage #(.IW(IW), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_F        (stall_F),
        .stall_D        (stall_D),
        .Flush_D        (Flush_D),
        .PC_W           (PC_W),
        .BranchTaken_W  (BranchTaken_W),
        .PCTarget_W     (PCTarget_W),
        .imem           (imem_bus.master),
        .instr_D        (instr_D),
        .pc_D           (pc_D),
        .valid_D        (valid_D),
        .op_D           (op_D),
        .branch_pending (branch_pending),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] rom [0:1023];
    always @(posedge clk) imem_bus.imem_rdata <= rom[imem_bus.imem_addr];

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int pc);
        exp_t e;
        e.pc    = AW'(pc);
        e.instr = rom[pc];
        sb.push_back(e);
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) push(i);
    endtask

    // One clock; a freshly loaded valid word must match the scoreboard head.
    task automatic step();
        exp_t e;
        chk("legal_stall", {31'd0, (stall_D && !stall_F)}, 32'd0);
        held = stall_D;
        @(posedge clk);
        #1;
        if (!held && valid_D === 1'b1) begin
            chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pc_D", 32'(pc_D), 32'(e.pc));
                chk("instr_D", instr_D, e.instr);
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rom_ident();
        for (int i = 0; i < 1024; i++) rom[i] = IW'(i);
    endtask

    task automatic clear_inputs();
        stall_F       = 1'b0;
        stall_D       = 1'b0;
        Flush_D       = 1'b0;
        PC_W          = 1'b0;
        BranchTaken_W = 1'b0;
        PCTarget_W    = '0;
    endtask

    task automatic apply_reset();
        sb.delete();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
    endtask

    task automatic drained(input string tag);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        rom_ident();

        // Reset values and sequential fetch with a 3-cycle full stall at pc 5.
        step();
        chk("rst_pc_D", 32'(pc_D), 32'd0);
        chk("rst_instr_D", instr_D, 32'd0);
        chk("rst_valid_D", {31'd0, valid_D}, 32'd0);
        chk("rst_op_D", {28'd0, op_D}, 32'd0);
        chk("rst_branch_pending", {31'd0, branch_pending}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_imem_addr", 32'(imem_bus.imem_addr), 32'd0);
        rst = 1'b0;
        push_range(0, 9);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("seq_valid", {31'd0, valid_D}, 32'd1);
        end
        stall_F = 1'b1;
        stall_D = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc_D", 32'(pc_D), 32'd5);
            chk("stall_instr_D", instr_D, 32'd5);
            chk("stall_valid_D", {31'd0, valid_D}, 32'd1);
            chk("stall_imem_addr", 32'(imem_bus.imem_addr), 32'd6);
        end
        stall_F = 1'b0;
        stall_D = 1'b0;
        steps(4);
        drained("seq_drained");

        // Taken branch at 8, target 40.
        rom_ident();
        rom[8] = {OP_BR0, 28'd8};
        apply_reset();
        push_range(0, 8);
        steps(9);
        chk("br_op_D", {28'd0, op_D}, {28'd0, OP_BR0});
        chk("br_pending", {31'd0, branch_pending}, 32'd1);
        chk("br_imem_addr", 32'(imem_bus.imem_addr), 32'd9);
        push_range(40, 43);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("br_wait_valid", {31'd0, valid_D}, 32'd0);
            chk("br_wait_pending", {31'd0, branch_pending}, 32'd1);
            chk("br_wait_imem_addr", 32'(imem_bus.imem_addr), 32'd9);
        end
        PC_W = 1'b1; BranchTaken_W = 1'b1; PCTarget_W = AW'(40);
        #1;
        chk("br_redirect_addr", 32'(imem_bus.imem_addr), 32'd40);
        step();
        chk("br_resolve_bubble", {31'd0, valid_D}, 32'd0);
        chk("br_resolve_pending", {31'd0, branch_pending}, 32'd0);
        clear_inputs();
        steps(4);
        drained("br_taken_drained");

        // Not-taken branch at 8.
        rom[8] = {OP_BR1, 28'd8};
        apply_reset();
        push_range(0, 8);
        steps(9);
        chk("nt_pending", {31'd0, branch_pending}, 32'd1);
        steps(2);
        PC_W = 1'b1; BranchTaken_W = 1'b0; PCTarget_W = AW'(40);
        #1;
        chk("nt_redirect_addr", 32'(imem_bus.imem_addr), 32'd9);
        step();
        clear_inputs();
        push_range(9, 11);
        steps(3);
        drained("nt_drained");

        // Flushed branch never enters WAIT_BR.
        rom[8] = {OP_BR0, 28'd8};
        apply_reset();
        push_range(0, 7);
        steps(8);
        Flush_D = 1'b1;
        step();
        Flush_D = 1'b0;
        chk("flush_bubble", {31'd0, valid_D}, 32'd0);
        chk("flush_no_pending", {31'd0, branch_pending}, 32'd0);
        push_range(9, 11);
        steps(3);
        drained("flush_drained");

        // Branch to 1022 then wrap through 1023 -> 0.
        apply_reset();
        push_range(0, 8);
        steps(11);
        PC_W = 1'b1; BranchTaken_W = 1'b1; PCTarget_W = AW'(1022);
        step();
        clear_inputs();
        push(1022); push(1023); push(0); push(1);
        steps(4);
        drained("wrap_drained");

        // Reset while a branch is pending.
        apply_reset();
        push_range(0, 8);
        steps(11);
        rst = 1'b1;
        sb.delete();
        step();
        chk("rstbr_pending", {31'd0, branch_pending}, 32'd0);
        chk("rstbr_valid", {31'd0, valid_D}, 32'd0);
        rst = 1'b0;
        push_range(0, 1);
        steps(2);
        drained("rstbr_drained");

        // HALT at 3, then reset recovers.
        rom_ident();
        rom[3] = {OP_HALT, 28'd3};
        apply_reset();
        push_range(0, 3);
        steps(4);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_op_D", {28'd0, op_D}, {28'd0, OP_HALT});
        for (int k = 0; k < 5; k++) begin
            step();
            chk("halt_bubble", {31'd0, valid_D}, 32'd0);
            chk("halt_stays", {31'd0, halted}, 32'd1);
            chk("halt_imem_addr", 32'(imem_bus.imem_addr), 32'd4);
        end
        rst = 1'b1;
        step();
        chk("halt_rst_flag", {31'd0, halted}, 32'd0);
        chk("halt_rst_valid", {31'd0, valid_D}, 32'd0);
        chk("halt_rst_pc_D", 32'(pc_D), 32'd0);
        chk("halt_rst_imem_addr", 32'(imem_bus.imem_addr), 32'd0);
        rst = 1'b0;
        push_range(0, 1);
        steps(2);
        drained("halt_drained");

        // Spurious PC_W while running is ignored.
        rom_ident();
        apply_reset();
        push_range(0, 7);
        steps(3);
        PC_W = 1'b1; BranchTaken_W = 1'b1; PCTarget_W = AW'(77);
        #1;
        chk("spur_imem_addr", 32'(imem_bus.imem_addr), 32'd4);
        step();
        clear_inputs();
        steps(4);
        chk("spur_no_pending", {31'd0, branch_pending}, 32'd0);
        drained("spur_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
